// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data load/store unit.
// Access sizes, FSM states and the alignment rule live here.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_B,
        LSU_H,
        LSU_W,
        LSU_BAD
    } lsu_size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } lsu_state_t;

    function automatic logic lsu_misaligned(lsu_size_t size, logic [1:0] a);
        logic mis;
        mis = 1'b0;
        unique case (size)
            LSU_H:   mis = a[0];
            LSU_W:   mis = |a;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extracts and extends load data, merges sub-word stores
// into the current RAM word (little-endian byte lanes).
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_t   size_i,
    input  logic        uns_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] ram_word_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_word_o,
    output logic [31:0] st_word_o
);

    logic [4:0]  sh;
    logic [31:0] shifted;

    always_comb begin
        sh        = {off_i, 3'b000};
        shifted   = ram_word_i >> sh;
        ld_word_o = ram_word_i;
        st_word_o = st_data_i;
        unique case (size_i)
            LSU_B: begin
                ld_word_o = {{24{~uns_i & shifted[7]}}, shifted[7:0]};
                st_word_o = (ram_word_i & ~(32'h0000_00FF << sh))
                          | ({24'b0, st_data_i[7:0]} << sh);
            end
            LSU_H: begin
                ld_word_o = {{16{~uns_i & shifted[15]}}, shifted[15:0]};
                st_word_o = (ram_word_i & ~(32'h0000_FFFF << sh))
                          | ({16'b0, st_data_i[15:0]} << sh);
            end
            default: begin
                ld_word_o = ram_word_i;
                st_word_o = st_data_i;
            end
        endcase
    end

endmodule

// File: rtl/data_lsu.sv
// Load/store unit: one request in flight, IDLE -> ACCESS -> RESP.
// Faulting accesses are reported in the response and never write RAM.
module data_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_raddr,
    input  logic [31:0] ram_rdata,
    output logic        ram_we,
    output logic [31:0] ram_waddr,
    output logic [31:0] ram_wdata
);

    lsu_state_t  state_q, state_d;
    logic        we_q;
    lsu_size_t   size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept;
    logic        err_w;
    logic [31:0] ld_word;
    logic [31:0] st_word;
    logic [31:0] word_idx;

    assign word_idx = {2'b00, addr_q[31:2]};
    assign err_w = (size_q == LSU_BAD)
                 | lsu_misaligned(size_q, addr_q[1:0])
                 | (word_idx >= RAM_WORDS);

    lsu_align u_align (
        .size_i     (size_q),
        .uns_i      (uns_q),
        .off_i      (addr_q[1:0]),
        .ram_word_i (ram_rdata),
        .st_data_i  (wdata_q),
        .ld_word_o  (ld_word),
        .st_word_o  (st_word)
    );

    assign ram_raddr  = word_idx;
    assign ram_waddr  = word_idx;
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = 32'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_we    = we_q & ~err_w;
                ram_wdata = st_word;
                err_d     = err_w;
                rdata_d   = (we_q | err_w) ? 32'b0 : ld_word;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= LSU_B;
            uns_q   <= 1'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= lsu_size_t'(req_size);
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_data_lsu.sv
// Self-checking bench for data_lsu against a byte-level memory model.
module tb_data_lsu;

    localparam int RW = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_raddr;
    logic [31:0] ram_rdata;
    logic        ram_we;
    logic [31:0] ram_waddr;
    logic [31:0] ram_wdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [RW];
    logic [31:0] model [RW];
    logic        clr;

    data_lsu #(.RAM_WORDS(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = (ram_raddr < RW) ? mem[ram_raddr[5:0]] : 32'b0;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < RW; i++) mem[i] <= 32'b0;
        end else if (ram_we && ram_waddr < RW) begin
            mem[ram_waddr[5:0]] <= ram_wdata;
        end
    end

    // Reference: byte-granular access against the model array.
    task automatic ref_op(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit er);
        int nb;
        int idx;
        int off;
        logic [31:0] v;
        nb  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        er  = (sz == 3) || (a % nb != 0) || ((a / 4) >= RW);
        rd  = 32'b0;
        if (er) return;
        idx = int'(a / 4);
        off = int'(a % 4);
        if (we) begin
            for (int i = 0; i < nb; i++)
                model[idx][8*(off+i) +: 8] = wd[8*i +: 8];
        end else begin
            v = 32'b0;
            for (int i = 0; i < nb; i++)
                v[8*i +: 8] = model[idx][8*(off+i) +: 8];
            if (!uns && nb < 4 && v[8*nb-1])
                for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
            rd = v;
        end
    endtask

    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd_o, output logic er_o);
        logic [31:0] exp_rd;
        bit exp_er;
        bit exp_we;
        ref_op(we, sz, uns, a, wd, exp_rd, exp_er);
        exp_we = we && !exp_er;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_idle: got %b exp 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (ram_we !== exp_we || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL access_phase @%h: ram_we %b valid %b exp we %b valid 0",
                     a, ram_we, resp_valid, exp_we);
        end
        if (exp_we) begin
            checks++;
            if (ram_waddr !== a >> 2 || ram_wdata !== model[a[7:2]]) begin
                errors++;
                $display("FAIL write_port @%h: waddr %h wdata %h exp %h %h",
                         a, ram_waddr, ram_wdata, a >> 2, model[a[7:2]]);
            end
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || ram_we !== 1'b0 ||
            resp_rdata !== exp_rd || resp_err !== exp_er) begin
            errors++;
            $display("FAIL resp @%h sz%0d we%0d: valid %b we %b rdata %h err %b exp 1 0 %h %b",
                     a, sz, we, resp_valid, ram_we, resp_rdata, resp_err, exp_rd, exp_er);
        end
        rd_o = resp_rdata;
        er_o = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b1;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; resp_ready = 0;
        for (int i = 0; i < RW; i++) model[i] = 32'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1 || resp_valid !== 0 || resp_rdata !== 0 ||
            resp_err !== 0 || ram_we !== 0 || ram_raddr !== 0 ||
            ram_waddr !== 0 || ram_wdata !== 0) begin
            errors++;
            $display("FAIL reset_state: rdy %b vld %b rd %h err %b we %b ra %h wa %h wd %h",
                     req_ready, resp_valid, resp_rdata, resp_err, ram_we,
                     ram_raddr, ram_waddr, ram_wdata);
        end
        clr = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic er;
        do_req(1, 2, 0, 32'h10, 32'hDEADBEEF, rd, er);
        do_req(0, 2, 0, 32'h10, 32'h0, rd, er);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 0) begin
            errors++;
            $display("FAIL lw_word: got %h err %b exp deadbeef 0", rd, er);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd;
        logic er;
        do_req(1, 2, 0, 32'h10, 32'h11223344, rd, er);
        do_req(1, 0, 0, 32'h12, 32'h000000AA, rd, er);
        do_req(0, 2, 0, 32'h10, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h11AA3344) begin
            errors++;
            $display("FAIL sb_merge: got %h exp 11aa3344", rd);
        end
        do_req(0, 0, 0, 32'h12, 32'h0, rd, er);
        checks++;
        if (rd !== 32'hFFFFFFAA) begin
            errors++;
            $display("FAIL lb: got %h exp ffffffaa", rd);
        end
        do_req(0, 0, 1, 32'h12, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h000000AA) begin
            errors++;
            $display("FAIL lbu: got %h exp 000000aa", rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd;
        logic er;
        do_req(1, 2, 0, 32'h14, 32'h0, rd, er);
        do_req(1, 1, 0, 32'h16, 32'h00008001, rd, er);
        do_req(0, 2, 0, 32'h14, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h80010000) begin
            errors++;
            $display("FAIL sh_merge: got %h exp 80010000", rd);
        end
        do_req(0, 1, 0, 32'h16, 32'h0, rd, er);
        checks++;
        if (rd !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL lh: got %h exp ffff8001", rd);
        end
        do_req(0, 1, 1, 32'h16, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h00008001) begin
            errors++;
            $display("FAIL lhu: got %h exp 00008001", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        logic [31:0] a_tab [5] = '{32'h11, 32'h13, 32'h18, 32'h18, RW*4};
        logic [1:0]  s_tab [5] = '{2'd2, 2'd1, 2'd3, 2'd3, 2'd2};
        bit          w_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            do_req(w_tab[i], s_tab[i], 0, a_tab[i], 32'hCAFEF00D, rd, er);
            checks++;
            if (er !== 1'b1 || rd !== 32'b0) begin
                errors++;
                $display("FAIL err_case%0d: err %b rdata %h exp 1 0", i, er, rd);
            end
        end
        checks++;
        if (mem[4] !== model[4] || mem[5] !== model[5] || mem[6] !== model[6]) begin
            errors++;
            $display("FAIL err_ram_unchanged: %h %h %h exp %h %h %h",
                     mem[4], mem[5], mem[6], model[4], model[5], model[6]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp1;
        logic [31:0] dummy;
        bit er;
        ref_op(0, 2, 0, 32'h10, 32'h0, exp1, er);
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 2; req_unsigned = 0;
        req_addr = 32'h10; req_wdata = 0; resp_ready = 0;
        @(negedge clk);
        req_we = 1; req_addr = 32'h24; req_wdata = 32'h5A5A1234;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1 || resp_rdata !== exp1 || req_ready !== 0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid %b rdata %h rdy %b exp 1 %h 0",
                         i, resp_valid, resp_rdata, req_ready, exp1);
            end
            if (i < 4) @(negedge clk);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        checks++;
        if (resp_valid !== 0 || req_ready !== 1) begin
            errors++;
            $display("FAIL bp_release: valid %b rdy %b exp 0 1", resp_valid, req_ready);
        end
        ref_op(1, 2, 0, 32'h24, 32'h5A5A1234, dummy, er);
        @(negedge clk);
        req_valid = 0;
        checks++;
        if (req_ready !== 0 || ram_we !== 1 || ram_waddr !== 32'd9) begin
            errors++;
            $display("FAIL bp_second: rdy %b we %b waddr %h exp 0 1 9",
                     req_ready, ram_we, ram_waddr);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1 || resp_err !== 0) begin
            errors++;
            $display("FAIL bp_second_resp: valid %b err %b exp 1 0", resp_valid, resp_err);
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2; req_unsigned = 0;
        req_addr = 32'h30; req_wdata = 32'h55AA55AA;
        @(negedge clk);
        req_valid = 0;
        checks++;
        if (ram_we !== 1) begin
            errors++;
            $display("FAIL rst_mid_access: ram_we %b exp 1", ram_we);
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if (ram_we !== 0 || resp_valid !== 0 || req_ready !== 1) begin
            errors++;
            $display("FAIL rst_mid_async: we %b valid %b rdy %b exp 0 0 1",
                     ram_we, resp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (mem[12] !== model[12] || req_ready !== 1 || resp_valid !== 0) begin
            errors++;
            $display("FAIL rst_mid_after: word %h rdy %b valid %b exp %h 1 0",
                     mem[12], req_ready, resp_valid, model[12]);
        end
        do_req(0, 2, 0, 32'h30, 32'h0, rd, er);
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic er;
        for (int n = 0; n < 60; n++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom_range(0, RW*4 + 15),
                   $urandom, rd, er);
        end
        for (int i = 0; i < RW; i++) begin
            checks++;
            if (mem[i] !== model[i]) begin
                errors++;
                $display("FAIL ram_word%0d: got %h exp %h", i, mem[i], model[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
